netbus_frame_buffer: RTL and testbench

Store-and-forward frame buffer on the consumer side of the 8-port NetBus receive arbiter, in the arbiter's read clock domain. It accepts the merged NetBus word stream and stores it. A frame is presented downstream only after its last word (bit 0 set) has been stored. Frames that do not fit are discarded whole, so a consumer never sees a partial frame.

---
 rtl/netbus_pkg.sv | 8 +
 rtl/netbus_sdp_ram.sv | 18 +
 rtl/netbus_frame_buffer.sv | 94 +++++++++
 tb/tb_netbus_frame_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/netbus_pkg.sv
// netbus_pkg: shared NetBus word geometry and write-side state type.
package netbus_pkg;
    localparam int NB_LAST_BIT = 0;
    typedef enum logic {NB_FILL, NB_DISCARD} nb_wstate_e;
    function automatic int NB_WORD_W(input int dw);
        return dw * 9 + 14;
    endfunction
endpackage

// File: rtl/netbus_sdp_ram.sv
// netbus_sdp_ram: simple dual-port RAM, synchronous write, asynchronous read.
module netbus_sdp_ram #(
    parameter int W  = 50,
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [2**AW];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/netbus_frame_buffer.sv
// netbus_frame_buffer: store-and-forward NetBus frame buffer; frames become
// visible only once their last word is stored, frames that do not fit are dropped whole.
module netbus_frame_buffer
    import netbus_pkg::*;
#(
    parameter int  DATA_WIDTH   = 4,
    parameter int  FIFO_DEPTH   = 6,
    parameter bit  DROP_ON_FULL = 1'b1,
    localparam int W            = NB_WORD_W(DATA_WIDTH)
) (
    input  logic                  RCLK,
    input  logic                  RESET,
    input  logic [W-1:0]          WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [W-1:0]          RDATA,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RFRAME,
    output logic [FIFO_DEPTH:0]   FRAME_COUNT,
    output logic [15:0]           DROP_COUNT,
    output logic                  OVERFLOW
);
    localparam int PW = FIFO_DEPTH + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] frame_count_q, frame_count_d, used;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          overflow_q, overflow_d;
    nb_wstate_e    state_q, state_d;
    logic          full, wr_acc, last, store, drop, commit, rd_acc, rd_last;

    // Extra pointer bit distinguishes a full buffer from an empty one.
    assign used    = wr_ptr_q - rd_ptr_q;
    assign full    = used == PW'(2**FIFO_DEPTH);
    assign last    = WDATA[NB_LAST_BIT];
    assign wr_acc  = WVALID && WREADY;
    assign store   = wr_acc && state_q == NB_FILL && !full;
    assign drop    = wr_acc && state_q == NB_FILL && full;
    assign commit  = store && last;
    assign rd_acc  = RVALID && RREADY;
    assign rd_last = rd_acc && RDATA[NB_LAST_BIT];

    // An oversized frame (full with nothing committed) is accepted and dropped to avoid deadlock.
    assign WREADY      = !RESET && (DROP_ON_FULL || !full || frame_count_q == '0 || state_q == NB_DISCARD);
    assign RVALID      = rd_ptr_q != wr_commit_q;
    assign RFRAME      = frame_count_q != '0;
    assign FRAME_COUNT = frame_count_q;
    assign DROP_COUNT  = drop_count_q;
    assign OVERFLOW    = overflow_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = drop ? wr_commit_q : store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        wr_commit_d   = commit ? wr_ptr_q + 1'b1 : wr_commit_q;
        rd_ptr_d      = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        frame_count_d = frame_count_q + PW'(commit) - PW'(rd_last);
        drop_count_d  = drop_count_q + 16'(drop && drop_count_q != 16'hFFFF);
        overflow_d    = drop;
        if (state_q == NB_FILL)
            state_d = drop && !last ? NB_DISCARD : NB_FILL;
        else
            state_d = wr_acc && last ? NB_FILL : NB_DISCARD;
    end

    always_ff @(posedge RCLK) begin
        if (RESET) begin
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            rd_ptr_q      <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            state_q       <= NB_FILL;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
        end
    end

    netbus_sdp_ram #(.W(W), .AW(FIFO_DEPTH)) u_ram (
        .clk_i   (RCLK),
        .we_i    (store),
        .waddr_i (wr_ptr_q[FIFO_DEPTH-1:0]),
        .wdata_i (WDATA),
        .raddr_i (rd_ptr_q[FIFO_DEPTH-1:0]),
        .rdata_o (RDATA)
    );
endmodule

// File: tb/tb_netbus_frame_buffer.sv
// tb_netbus_frame_buffer: scoreboard bench for the frame buffer in drop and backpressure modes.
module tb_netbus_frame_buffer;
    localparam int W  = 50;
    localparam int FD = 3;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic [W-1:0] WDATA = '0;
    logic WVALID = 1'b0;
    logic RREADY = 1'b0;
    bit   mode = 1'b1;
    bit   chk_en = 1'b0;
    bit   rnd_rdy = 1'b0;

    logic a_wready, a_rvalid, a_rframe, a_ovf, b_wready, b_rvalid, b_rframe, b_ovf;
    logic [W-1:0] a_rdata, b_rdata;
    logic [FD:0] a_fc, b_fc;
    logic [15:0] a_dc, b_dc;
    logic wready, rvalid, rframe, overflow;
    logic [W-1:0] rdata;
    logic [FD:0] frame_count;
    logic [15:0] drop_count;

    int n_tests = 0, n_fail = 0, rd_words = 0, ovf_pulses = 0;
    logic [W-1:0] exp_q[$], pend_q[$];
    int m_fc = 0, m_drop = 0;
    bit m_ovf = 0, m_disc = 0;

    always #5 clk = ~clk;

    netbus_frame_buffer #(.DATA_WIDTH(4), .FIFO_DEPTH(FD), .DROP_ON_FULL(1'b1)) u_drop (
        .RCLK(clk), .RESET(RESET), .WDATA(WDATA), .WVALID(WVALID), .WREADY(a_wready),
        .RDATA(a_rdata), .RVALID(a_rvalid), .RREADY(RREADY), .RFRAME(a_rframe),
        .FRAME_COUNT(a_fc), .DROP_COUNT(a_dc), .OVERFLOW(a_ovf));

    netbus_frame_buffer #(.DATA_WIDTH(4), .FIFO_DEPTH(FD), .DROP_ON_FULL(1'b0)) u_bp (
        .RCLK(clk), .RESET(RESET), .WDATA(WDATA), .WVALID(WVALID), .WREADY(b_wready),
        .RDATA(b_rdata), .RVALID(b_rvalid), .RREADY(RREADY), .RFRAME(b_rframe),
        .FRAME_COUNT(b_fc), .DROP_COUNT(b_dc), .OVERFLOW(b_ovf));

    assign wready      = mode ? a_wready : b_wready;
    assign rvalid      = mode ? a_rvalid : b_rvalid;
    assign rframe      = mode ? a_rframe : b_rframe;
    assign overflow    = mode ? a_ovf    : b_ovf;
    assign rdata       = mode ? a_rdata  : b_rdata;
    assign frame_count = mode ? a_fc     : b_fc;
    assign drop_count  = mode ? a_dc     : b_dc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: evaluates outputs, then predicts the effect of the coming edge.
    always @(negedge clk) begin
        bit full;
        full = (pend_q.size() + exp_q.size()) == 2**FD;
        if (chk_en) begin
            check("wready", 64'(wready), 64'(!RESET && (mode || !full || m_fc == 0 || m_disc)));
            check("rvalid", 64'(rvalid), 64'(exp_q.size() != 0));
            check("rframe", 64'(rframe), 64'(m_fc != 0));
            check("frame_count", 64'(frame_count), 64'(m_fc));
            check("drop_count", 64'(drop_count), 64'(m_drop));
            check("overflow", 64'(overflow), 64'(m_ovf));
            ovf_pulses += int'(overflow === 1'b1);
        end
        m_ovf = 0;
        if (RESET) begin
            exp_q.delete();
            pend_q.delete();
            m_fc = 0;
            m_drop = 0;
            m_disc = 0;
        end else begin
            if (rvalid === 1'b1 && RREADY && exp_q.size() != 0) begin
                check("rdata", 64'(rdata), 64'(exp_q[0]));
                rd_words++;
                if (exp_q[0][0]) m_fc--;
                void'(exp_q.pop_front());
            end
            if (WVALID && wready === 1'b1) begin
                if (m_disc) begin
                    if (WDATA[0]) m_disc = 0;
                end else if (!full) begin
                    pend_q.push_back(WDATA);
                    if (WDATA[0]) begin
                        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                        pend_q.delete();
                        m_fc++;
                    end
                end else begin
                    pend_q.delete();
                    if (m_drop != 16'hFFFF) m_drop++;
                    m_ovf = 1;
                    if (!WDATA[0]) m_disc = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) RREADY = 1'($urandom_range(0, 1));
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rword(input bit last);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {r[W-1:1], last};
    endfunction

    task automatic put_word(input logic [W-1:0] w);
        bit ok;
        ok = 0;
        WDATA = w;
        WVALID = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = wready === 1'b1;
            step();
        end
        WVALID = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic send_frame(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            put_word(rword(i == len - 1));
            if (gaps && $urandom_range(0, 3) == 0) step($urandom_range(1, 2));
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) step();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input bit new_mode);
        chk_en = 0;
        RESET = 1'b1;
        step();
        mode = new_mode;
        step();
        chk_en = 1;
        RESET = 1'b0;
    endtask

    initial begin
        int r0, tot;
        step(2);
        chk_en = 1;
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rframe", 64'(rframe), 64'd0);
        check("rst_fc", 64'(frame_count), 64'd0);
        check("rst_dc", 64'(drop_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        RESET = 1'b0;
        step();

        // basic 3-word frame
        RREADY = 1'b1;
        r0 = rd_words;
        send_frame(3, 0);
        check("basic_rvalid", 64'(rvalid), 64'd1);
        check("basic_fc", 64'(frame_count), 64'd1);
        drain();
        step();
        check("basic_fc_end", 64'(frame_count), 64'd0);
        check("basic_words", 64'(rd_words - r0), 64'd3);

        // completion gate
        r0 = rd_words;
        for (int i = 0; i < 4; i++) put_word(rword(0));
        step(10);
        check("gate_rvalid", 64'(rvalid), 64'd0);
        put_word(rword(1));
        drain();
        check("gate_words", 64'(rd_words - r0), 64'd5);

        // drop on full
        RREADY = 1'b0;
        r0 = rd_words;
        ovf_pulses = 0;
        send_frame(6, 0);
        send_frame(4, 0);
        step(2);
        check("drop_dc", 64'(drop_count), 64'd1);
        check("drop_fc", 64'(frame_count), 64'd1);
        check("drop_pulses", 64'(ovf_pulses), 64'd1);
        RREADY = 1'b1;
        drain();
        check("drop_words", 64'(rd_words - r0), 64'd6);

        // oversize in backpressure mode
        do_reset(1'b0);
        r0 = rd_words;
        send_frame(12, 0);
        send_frame(2, 0);
        drain();
        step(2);
        check("over_dc", 64'(drop_count), 64'd1);
        check("over_words", 64'(rd_words - r0), 64'd2);

        // wrap with random RREADY
        r0 = rd_words;
        tot = 0;
        rnd_rdy = 1;
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 4);
            tot += len;
            send_frame(len, 1);
        end
        rnd_rdy = 0;
        step();
        RREADY = 1'b1;
        drain();
        check("wrap_words", 64'(rd_words - r0), 64'(tot));
        check("wrap_dc", 64'(drop_count), 64'd1);

        // reset mid-frame
        RREADY = 1'b0;
        put_word(rword(0));
        put_word(rword(0));
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rvalid", 64'(rvalid), 64'd0);
        check("mid_fc", 64'(frame_count), 64'd0);
        check("mid_dc", 64'(drop_count), 64'd0);
        check("mid_ovf", 64'(overflow), 64'd0);
        r0 = rd_words;
        RREADY = 1'b1;
        send_frame(3, 0);
        drain();
        check("mid_words", 64'(rd_words - r0), 64'd3);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
